// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: two-flop synchroniser, stable-count debounce
// filter, and registered press / release / long-hold pulses per channel.
module button_conditioner #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] held,
    output logic                any_pressed
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic INV = ACTIVE_LOW;

    logic [CHANNELS-1:0] press_d_vec;
    logic                any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic             s1_q, s2_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;
        logic             prs_q, prs_d;
        logic             rel_q, rel_d;

        // Synchroniser stage: flops carry the logical (active-high) level.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= button[i] ^ INV;
                s2_q <= s1_q;
            end
        end

        // Filter stage: any sample matching the current level restarts the count.
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            prs_d = 1'b0;
            rel_d = 1'b0;
            if (s2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = s2_q;
                    prs_d = s2_q;
                    rel_d = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
                prs_q <= prs_d;
                rel_q <= rel_d;
            end
        end

        assign press_d_vec[i] = prs_d;
        assign debounced[i]   = deb_q;
        assign pressed[i]     = prs_q;
        assign released[i]    = rel_q;

        if (HOLD_CYCLES > 0) begin : gen_hold
            localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
            localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_CYCLES);
            localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(HOLD_CYCLES - 1);

            logic [HCNT_W-1:0] hcnt_q, hcnt_d;
            logic              hld_q, hld_d;

            // Hold stage: keyed off the next debounced level so a release on the
            // hold-point edge suppresses the pulse; saturates so it fires once.
            always_comb begin
                hcnt_d = hcnt_q;
                hld_d  = 1'b0;
                if (!deb_d || prs_d) begin
                    hcnt_d = '0;
                end else if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                    hld_d  = (hcnt_q == HCNT_FIRE);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    hcnt_q <= '0;
                    hld_q  <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    hld_q  <= hld_d;
                end
            end

            assign held[i] = hld_q;
        end else begin : gen_no_hold
            assign held[i] = 1'b0;
        end
    end

    // Output stage: registered OR so it lines up with the per-channel pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |press_d_vec;
        end
    end

    assign any_pressed = any_q;

endmodule
